// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Time-multiplexes one perceptron datapath over every neuron of a fully
//   connected layer. For each neuron it primes the perceptron with that
//   neuron's weight base and streams the layer input vector from the input
//   buffer. It then waits for the result, applies an optional ReLU and writes
//   the result to the output buffer.
//
// Ports
//   s_axi_aclk, s_axi_aresetn   clock, asynchronous active-low reset
//   layer_start, relu_en        host kick (one-cycle pulse), ReLU select
//   busy, layer_done, err       layer status; err is a sticky timeout flag
//   x_raddr / x_rdata           input buffer read port (1-cycle latency)
//   x_tdata/x_tvalid/x_tready   input stream to the perceptron
//   p_start, p_wbase            per-neuron pass enable and weight base
//   p_done, p_acc               perceptron result handshake and value
//   neuron_idx                  neuron currently being processed
//   y_we, y_waddr, y_wdata      output buffer write port
module layer_sequencer #(
    parameter  int DATA_W  = 32,
    parameter  int INPUTS  = 784,
    parameter  int NEURONS = 10,
    parameter  int ADDR_W  = 10,
    parameter  int TIMEOUT = 64,
    localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              layer_start,
    input  logic              relu_en,
    output logic              busy,
    output logic              layer_done,
    output logic              err,
    output logic [ADDR_W-1:0] x_raddr,
    input  logic [DATA_W-1:0] x_rdata,
    output logic [DATA_W-1:0] x_tdata,
    output logic              x_tvalid,
    input  logic              x_tready,
    output logic              p_start,
    output logic [ADDR_W-1:0] p_wbase,
    input  logic              p_done,
    input  logic [DATA_W-1:0] p_acc,
    output logic [NW-1:0]     neuron_idx,
    output logic              y_we,
    output logic [NW-1:0]     y_waddr,
    output logic [DATA_W-1:0] y_wdata
);

    localparam int CW = $clog2(INPUTS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        WAIT,
        WRITE
    } state_t;

    state_t            state;
    logic              relu_q;
    logic              rd_pend;     // a read was issued last cycle; data is on x_rdata now
    logic [DATA_W-1:0] fifo [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        cnt;
    logic [CW-1:0]     rd_n;        // reads issued in this pass
    logic [CW-1:0]     beat_n;      // beats accepted in this pass
    logic [TW-1:0]     tmo;

    logic              in_stream;
    logic              pop;
    logic              pop_fifo;
    logic              push;
    logic              issue;
    logic [1:0]        occ;
    logic              last_neuron;

    // Stream head: buffered entry if any, otherwise the read data arriving this
    // cycle is forwarded directly so the first beat appears right after PRIME.
    // Unaccepted forwarded data is pushed into the buffer, which keeps x_tdata
    // stable across stalls.
    always_comb begin
        in_stream = (state == STREAM);
        x_tvalid  = in_stream && ((cnt != 2'd0) || rd_pend);
        if (!x_tvalid)
            x_tdata = '0;
        else if (cnt == 2'd0)
            x_tdata = x_rdata;
        else
            x_tdata = fifo[rptr];
        pop      = x_tvalid && x_tready;
        pop_fifo = pop && (cnt != 2'd0);
        push     = rd_pend && !(pop && (cnt == 2'd0));
        // Occupancy after this cycle, counting the read already in flight.
        occ      = cnt + 2'(rd_pend) - 2'(pop);
        issue    = in_stream && (rd_n < CW'(INPUTS)) && (occ < 2'd2);
        last_neuron = (neuron_idx == NW'(NEURONS - 1));
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state      <= IDLE;
            relu_q     <= 1'b0;
            rd_pend    <= 1'b0;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            cnt        <= 2'd0;
            rd_n       <= '0;
            beat_n     <= '0;
            tmo        <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            err        <= 1'b0;
            x_raddr    <= '0;
            p_start    <= 1'b0;
            p_wbase    <= '0;
            neuron_idx <= '0;
            y_we       <= 1'b0;
            y_waddr    <= '0;
            y_wdata    <= '0;
        end else begin
            y_we       <= 1'b0;
            layer_done <= 1'b0;

            // Prefetch buffer and read issue
            if (push) begin
                fifo[wptr] <= x_rdata;
                wptr       <= ~wptr;
            end
            if (pop_fifo)
                rptr <= ~rptr;
            cnt     <= cnt + 2'(push) - 2'(pop_fifo);
            rd_pend <= issue;
            if (issue) begin
                rd_n <= rd_n + CW'(1);
                if (rd_n < CW'(INPUTS - 1))
                    x_raddr <= x_raddr + ADDR_W'(1);
            end
            if (pop)
                beat_n <= beat_n + CW'(1);

            case (state)
                IDLE: begin
                    if (layer_start) begin
                        err        <= 1'b0;
                        relu_q     <= relu_en;
                        neuron_idx <= '0;
                        p_wbase    <= '0;
                        x_raddr    <= '0;
                        busy       <= 1'b1;
                        p_start    <= 1'b1;
                        state      <= PRIME;
                    end
                end
                PRIME: begin
                    // Address 0 is being read this cycle.
                    rd_pend <= 1'b1;
                    rd_n    <= CW'(1);
                    beat_n  <= '0;
                    wptr    <= 1'b0;
                    rptr    <= 1'b0;
                    x_raddr <= ADDR_W'(1);
                    state   <= STREAM;
                end
                STREAM: begin
                    if (pop && (beat_n == CW'(INPUTS - 1))) begin
                        tmo   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (p_done || (tmo == TW'(TIMEOUT - 1))) begin
                        if (p_done)
                            y_wdata <= (relu_q && p_acc[DATA_W-1]) ? '0 : p_acc;
                        else begin
                            y_wdata <= '0;
                            err     <= 1'b1;
                        end
                        y_we       <= 1'b1;
                        y_waddr    <= neuron_idx;
                        p_start    <= 1'b0;
                        layer_done <= last_neuron;
                        state      <= WRITE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                WRITE: begin
                    x_raddr <= '0;
                    if (last_neuron) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        neuron_idx <= neuron_idx + NW'(1);
                        p_wbase    <= p_wbase + ADDR_W'(INPUTS);
                        p_start    <= 1'b1;
                        state      <= PRIME;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed testbench for layer_sequencer (INPUTS=5, NEURONS=3, TIMEOUT=8).
// A small perceptron model answers p_done two cycles after each neuron's last
// beat, a 1-cycle-latency buffer model serves x_rdata, and a negedge monitor
// records stream and output-buffer activity for the directed checks.
module tb_layer_sequencer;

    localparam int DATA_W  = 32;
    localparam int INPUTS  = 5;
    localparam int NEURONS = 3;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 8;
    localparam int NW      = 2;

    logic              clk;
    logic              s_axi_aresetn;
    logic              layer_start;
    logic              relu_en;
    logic              busy;
    logic              layer_done;
    logic              err;
    logic [ADDR_W-1:0] x_raddr;
    logic [DATA_W-1:0] x_rdata;
    logic [DATA_W-1:0] x_tdata;
    logic              x_tvalid;
    logic              x_tready;
    logic              p_start;
    logic [ADDR_W-1:0] p_wbase;
    logic              p_done;
    logic              p_done_m;
    logic              spur;
    logic [DATA_W-1:0] p_acc;
    logic [NW-1:0]     neuron_idx;
    logic              y_we;
    logic [NW-1:0]     y_waddr;
    logic [DATA_W-1:0] y_wdata;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [DATA_W-1:0] buf_v   [INPUTS]  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [DATA_W-1:0] acc_tab [NEURONS] = '{32'd56, 32'hFFFF_FFF9, 32'd0};
    int hang_n = -1;

    layer_sequencer #(
        .DATA_W (DATA_W),
        .INPUTS (INPUTS),
        .NEURONS(NEURONS),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(s_axi_aresetn),
        .layer_start  (layer_start),
        .relu_en      (relu_en),
        .busy         (busy),
        .layer_done   (layer_done),
        .err          (err),
        .x_raddr      (x_raddr),
        .x_rdata      (x_rdata),
        .x_tdata      (x_tdata),
        .x_tvalid     (x_tvalid),
        .x_tready     (x_tready),
        .p_start      (p_start),
        .p_wbase      (p_wbase),
        .p_done       (p_done),
        .p_acc        (p_acc),
        .neuron_idx   (neuron_idx),
        .y_we         (y_we),
        .y_waddr      (y_waddr),
        .y_wdata      (y_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign p_done = p_done_m | spur;

    // Input buffer: 1-cycle read latency
    always @(posedge clk) begin
        if (x_raddr < ADDR_W'(INPUTS))
            x_rdata <= buf_v[x_raddr];
        else
            x_rdata <= 32'hBAD0_0000;
    end

    // Perceptron model
    int pend = 0;
    int mbc  = 0;
    int mn   = 0;
    int fire_idx = 0;
    initial begin
        p_done_m = 1'b0;
        p_acc    = 32'h5A5A_5A5A;
    end
    always @(posedge clk) begin
        p_done_m <= 1'b0;
        if (!s_axi_aresetn) begin
            pend = 0;
            mbc  = 0;
            mn   = 0;
        end else begin
            if (pend == 1) begin
                p_done_m <= 1'b1;
                p_acc    <= acc_tab[fire_idx];
                pend = 0;
            end else if (pend > 1) begin
                pend = pend - 1;
            end
            if (layer_start && !busy) begin
                mbc  = 0;
                mn   = 0;
                pend = 0;
            end else if (x_tvalid && x_tready) begin
                if (mbc == INPUTS - 1) begin
                    mbc = 0;
                    if (mn != hang_n && mn < NEURONS) begin
                        pend     = 1;
                        fire_idx = mn;
                    end
                    mn = mn + 1;
                end else begin
                    mbc = mbc + 1;
                end
            end
        end
    end

    // Monitor (observations only; expectations live in the main sequence)
    logic [DATA_W-1:0] y_mem [4];
    int m_beats, m_k, m_nb, m_beat_err, m_stall_err, m_wb_err;
    int m_ywe, m_ld, m_ld_noywe, m_oob;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    initial begin
        for (int i = 0; i < 4; i++) y_mem[i] = 32'hDEAD_BEEF;
        m_beats = 0; m_k = 0; m_nb = 0; m_beat_err = 0; m_stall_err = 0;
        m_wb_err = 0; m_ywe = 0; m_ld = 0; m_ld_noywe = 0; m_oob = 0;
        prev_stall = 1'b0; prev_data = '0;
    end
    always @(negedge clk) begin
        if (layer_start && !busy) begin
            for (int i = 0; i < 4; i++) y_mem[i] = 32'hDEAD_BEEF;
            m_beats = 0; m_k = 0; m_nb = 0; m_beat_err = 0; m_stall_err = 0;
            m_wb_err = 0; m_ywe = 0; m_ld = 0; m_ld_noywe = 0; m_oob = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!x_tvalid || x_tdata !== prev_data))
                m_stall_err = m_stall_err + 1;
            if (x_tvalid && x_tready) begin
                if (x_tdata !== buf_v[m_k]) m_beat_err = m_beat_err + 1;
                if (p_wbase !== ADDR_W'(m_nb * INPUTS) || p_start !== 1'b1)
                    m_wb_err = m_wb_err + 1;
                m_beats = m_beats + 1;
                if (m_k == INPUTS - 1) begin
                    m_k  = 0;
                    m_nb = m_nb + 1;
                end else begin
                    m_k = m_k + 1;
                end
            end
            prev_stall = s_axi_aresetn && x_tvalid && !x_tready;
            prev_data  = x_tdata;
            if (x_raddr >= ADDR_W'(INPUTS)) m_oob = m_oob + 1;
            if (y_we) begin
                y_mem[y_waddr] = y_wdata;
                m_ywe = m_ywe + 1;
            end
            if (layer_done) begin
                m_ld = m_ld + 1;
                if (!y_we) m_ld_noywe = m_ld_noywe + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string t);
        chk({t, ".busy"},       32'(busy),       32'd0);
        chk({t, ".layer_done"}, 32'(layer_done), 32'd0);
        chk({t, ".err"},        32'(err),        32'd0);
        chk({t, ".x_tvalid"},   32'(x_tvalid),   32'd0);
        chk({t, ".p_start"},    32'(p_start),    32'd0);
        chk({t, ".y_we"},       32'(y_we),       32'd0);
        chk({t, ".x_raddr"},    32'(x_raddr),    32'd0);
        chk({t, ".x_tdata"},    x_tdata,         32'd0);
        chk({t, ".p_wbase"},    32'(p_wbase),    32'd0);
        chk({t, ".neuron_idx"}, 32'(neuron_idx), 32'd0);
        chk({t, ".y_waddr"},    32'(y_waddr),    32'd0);
        chk({t, ".y_wdata"},    y_wdata,         32'd0);
    endtask

    // Runs one layer. Cycle 0 is the layer_start cycle; c counts cycles after it.
    task automatic run_layer(input string t, input bit rnd, input bit relu, input bit tchk,
                             input int spur_at, input int busy_at);
        bit ok;
        int c_done;
        ok = 1'b0;
        c_done = -1;
        @(posedge clk); #1;
        layer_start = 1'b1;
        relu_en     = relu;
        x_tready    = 1'b1;
        @(negedge clk);
        if (tchk) chk({t, ".busy_c0"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        layer_start = 1'b0;
        for (int c = 1; c < 400 && !ok; c++) begin
            x_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            spur     = (c == spur_at);
            if (c == busy_at) begin
                layer_start = 1'b1;
                relu_en     = ~relu;
            end
            @(negedge clk);
            if (c == 1) chk({t, ".err_clr"}, 32'(err), 32'd0);
            if (tchk && c == 1) begin
                chk({t, ".busy_c1"},    32'(busy),     32'd1);
                chk({t, ".pstart_c1"},  32'(p_start),  32'd1);
                chk({t, ".raddr_c1"},   32'(x_raddr),  32'd0);
                chk({t, ".tvalid_c1"},  32'(x_tvalid), 32'd0);
            end
            if (tchk && c == 2) begin
                chk({t, ".tvalid_c2"},  32'(x_tvalid), 32'd1);
                chk({t, ".tdata_c2"},   x_tdata,       32'd1);
            end
            if (tchk && c == 7) begin
                chk({t, ".tvalid_wait"}, 32'(x_tvalid), 32'd0);
                chk({t, ".pstart_wait"}, 32'(p_start),  32'd1);
            end
            if (tchk && c == 9) begin
                chk({t, ".ywe_c9"},    32'(y_we),    32'd1);
                chk({t, ".ywdata_c9"}, y_wdata,      32'd56);
                chk({t, ".ywaddr_c9"}, 32'(y_waddr), 32'd0);
                chk({t, ".pstart_c9"}, 32'(p_start), 32'd0);
            end
            if (tchk && c == 10) begin
                chk({t, ".nidx_c10"},   32'(neuron_idx), 32'd1);
                chk({t, ".wbase_c10"},  32'(p_wbase),    32'd5);
                chk({t, ".raddr_c10"},  32'(x_raddr),    32'd0);
                chk({t, ".pstart_c10"}, 32'(p_start),    32'd1);
            end
            if (layer_done) begin
                ok     = 1'b1;
                c_done = c;
            end
            @(posedge clk); #1;
            spur        = 1'b0;
            layer_start = 1'b0;
            relu_en     = relu;
        end
        chk({t, ".layer_done_seen"}, 32'(ok), 32'd1);
        if (tchk) chk({t, ".done_cycle"}, 32'(c_done), 32'd27);
        x_tready = 1'b1;
        @(negedge clk);
        chk({t, ".busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic check_layer(input string t, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic e_err);
        chk({t, ".y0"},        y_mem[0],            e0);
        chk({t, ".y1"},        y_mem[1],            e1);
        chk({t, ".y2"},        y_mem[2],            e2);
        chk({t, ".y3_unused"}, y_mem[3],            32'hDEAD_BEEF);
        chk({t, ".ywe_count"}, 32'(m_ywe),          32'd3);
        chk({t, ".done_cnt"},  32'(m_ld),           32'd1);
        chk({t, ".done_ywe"},  32'(m_ld_noywe),     32'd0);
        chk({t, ".beats"},     32'(m_beats),        32'd15);
        chk({t, ".beat_data"}, 32'(m_beat_err),     32'd0);
        chk({t, ".stall"},     32'(m_stall_err),    32'd0);
        chk({t, ".wbase"},     32'(m_wb_err),       32'd0);
        chk({t, ".raddr_oob"}, 32'(m_oob),          32'd0);
        chk({t, ".err"},       32'(err),            32'(e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_aresetn = 1'b0;
        layer_start   = 1'b0;
        relu_en       = 1'b0;
        x_tready      = 1'b0;
        spur          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        s_axi_aresetn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: basic layer, no ReLU
        run_layer("t1", 1'b0, 1'b0, 1'b1, -1, -1);
        check_layer("t1", 32'd56, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // 2: ReLU clamps the negative result
        run_layer("t2", 1'b0, 1'b1, 1'b0, -1, -1);
        check_layer("t2", 32'd56, 32'd0, 32'd0, 1'b0);

        // 3: random backpressure
        run_layer("t3", 1'b1, 1'b0, 1'b0, -1, -1);
        check_layer("t3", 32'd56, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // 4: neuron 1 never answers; busy layer_start after the timeout keeps err
        hang_n = 1;
        run_layer("t4", 1'b0, 1'b0, 1'b0, -1, 26);
        check_layer("t4", 32'd56, 32'd0, 32'd0, 1'b1);
        hang_n = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4.err_sticky", 32'(err), 32'd1);

        // 5: spurious p_done in STREAM, layer_start (with relu_en=1) while busy
        run_layer("t5", 1'b0, 1'b0, 1'b0, 3, 4);
        check_layer("t5", 32'd56, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // 6: reset during neuron 1's third beat (cycle 13)
        @(posedge clk); #1;
        layer_start = 1'b1;
        relu_en     = 1'b0;
        x_tready    = 1'b1;
        @(posedge clk); #1;
        layer_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t6.pre_tvalid", 32'(x_tvalid),   32'd1);
        chk("t6.pre_tdata",  x_tdata,         32'd3);
        chk("t6.pre_nidx",   32'(neuron_idx), 32'd1);
        s_axi_aresetn = 1'b0;
        #1;
        check_reset("t6.rst_now");
        repeat (3) @(posedge clk);
        #1;
        check_reset("t6.rst_hold");
        s_axi_aresetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6.no_more_ywe", 32'(m_ywe), 32'd1);
        chk("t6.y1_unwritten", y_mem[1],  32'hDEAD_BEEF);
        chk("t6.busy_after",  32'(busy),  32'd0);
        chk("t6.no_done",     32'(m_ld),  32'd0);

        // fresh layer reproduces test 1
        run_layer("t6b", 1'b0, 1'b0, 1'b1, -1, -1);
        check_layer("t6b", 32'd56, 32'hFFFF_FFF9, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one shared perceptron datapath across all neurons of a fully connected layer. For each neuron in turn it:
- points the perceptron at that neuron's weight slice;
- asserts start and streams the layer's input vector from the input buffer;
- waits for done, then captures the accumulator;
- applies optional ReLU and writes the result to the output buffer.

It sits between the layer input/output buffers and the perceptron, and is kicked by the host once per layer.

## Interface
Parameters:
- DATA_W, 32, width of x, weights, accumulator and outputs
- INPUTS, 784, input vector length (≥2)
- NEURONS, 10, neurons in the layer (≥1)
- ADDR_W, 10, input buffer / weight address width
- TIMEOUT, 64, max cycles from last accepted beat to p_done

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- layer_start  in  1  one-cycle pulse; ignored while busy
- relu_en  in  1  sampled at layer_start; 1 = clamp negative results to 0
- busy  out  1  high from the cycle after an accepted layer_start until layer_done
- layer_done  out  1  one-cycle pulse when the last neuron is written
- err  out  1  sticky timeout flag; cleared by the next accepted layer_start
- x_raddr  out  ADDR_W  input buffer read address; read latency is 1 cycle
- x_rdata  in  DATA_W  input buffer read data
- x_tdata  out  DATA_W  stream to the perceptron
- x_tvalid  out  1  stream valid
- x_tready  in  1  stream ready
- p_start  out  1  level; high for the whole duration of one neuron's pass
- p_wbase  out  ADDR_W  weight base address = neuron_idx*INPUTS
- p_done  in  1  perceptron result valid
- p_acc  in  DATA_W  perceptron result (a_tdata), signed two's complement
- neuron_idx  out  clog2(NEURONS)  neuron currently being processed
- y_we  out  1  output buffer write strobe
- y_waddr  out  clog2(NEURONS)  output address = neuron_idx
- y_wdata  out  DATA_W  output data

## Operation
States: IDLE, PRIME, STREAM, WAIT, WRITE.

- IDLE:
  - on layer_start: clear err, latch relu_en, set neuron_idx=0, go to PRIME.
- PRIME:
  - assert p_start.
  - drive p_wbase and x_raddr=0.
  - next cycle, go to STREAM.
- STREAM:
  - present INPUTS beats, element k = buffer[k], strictly in order, with no gaps or repeats.
  - a beat transfers only when x_tvalid && x_tready.
  - x_tvalid stays high and x_tdata stays stable while x_tready is low.
  - a 2-entry prefetch buffer sustains 1 beat/cycle while x_tready is high.
  - reads never run past address INPUTS-1.
  - after the last beat is accepted, go to WAIT.
- WAIT:
  - x_tvalid=0 and p_start stays high.
  - on p_done: capture r = (relu_en_latched && p_acc[DATA_W-1]) ? 0 : p_acc, then go to WRITE.
  - if TIMEOUT cycles elapse with no p_done: set err, capture r=0, go to WRITE.
- WRITE:
  - y_we=1 for exactly one cycle with y_waddr=neuron_idx and y_wdata=r.
  - p_start drops to 0 in this cycle.
  - if neuron_idx==NEURONS-1: pulse layer_done and go to IDLE.
  - otherwise: increment neuron_idx and go to PRIME.

Other rules:
- p_done asserted outside WAIT is ignored.
- layer_start outside IDLE is ignored and does not clear err.
- Asynchronous reset, at any point including mid-stream:
  - state returns to IDLE;
  - the prefetch buffer is emptied;
  - the layer is abandoned and no y_we is issued.
  - Reset values: busy=0, layer_done=0, err=0, x_tvalid=0, p_start=0, y_we=0, x_raddr=0, x_tdata=0, p_wbase=0, neuron_idx=0, y_waddr=0, y_wdata=0.
- No arithmetic beyond the sign test; p_acc passes through unmodified when not clamped.

## Timing
- Cycle 0: layer_start high.
- Cycle 1: busy=1, state PRIME, p_start=1, x_raddr=0.
- Cycle 2: first x_tvalid=1 with x_tdata=buffer[0].
- With x_tready held high, beats occupy cycles 2..INPUTS+1 and WAIT begins at cycle INPUTS+2.
- y_we occurs the cycle after p_done is seen in WAIT.
- The next neuron's PRIME immediately follows WRITE.
- Neuron pass cost: INPUTS + 3 + (p_done latency) cycles with no backpressure.
- layer_done coincides with the final y_we.
- busy falls the cycle after layer_done.

## Test plan
1. INPUTS=5, NEURONS=3, buffer={1,2,3,4,5}, x_tready=1, model replies p_done 2 cycles after the last beat with p_acc={56,-7,0}, relu_en=0:
   - beats 1..5 on consecutive cycles for each neuron;
   - p_wbase = 0, 5, 10;
   - y writes {56, 0xFFFFFFF9, 0} at addresses 0..2;
   - one layer_done; err=0.
2. Same as 1 with relu_en=1 → y = {56, 0, 0}.
3. Random x_tready (≈50% duty) → identical beat sequence, x_tdata stable while stalled, same outputs as 1.
4. Model never asserts p_done for neuron 1, TIMEOUT=8:
   - err=1, y[1]=0, y[0] and y[2] still correct;
   - err stays 1 after layer_done;
   - err clears on the next layer_start.
5. Pulse layer_start while busy and a spurious p_done during STREAM → no effect, outputs same as 1.
6. Assert s_axi_aresetn=0 during neuron 1's third beat:
   - all outputs at reset values immediately;
   - no further y_we;
   - a fresh layer_start after release reproduces test 1 exactly.
